memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 153 +++++++++++++++
 tb/tb_memory_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Memory stage of a five-stage pipeline: captures one instruction from execute,
// performs an optional data-memory access with timeout, and retires to writeback.
module memory_stage #(
  parameter int DMEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic [31:0] instruction_i,
  input  logic [63:0] branch_addr_i,
  input  logic [63:0] alu_result_i,
  input  logic [63:0] store_data_i,
  input  logic        zero_i,
  input  logic        b_i,
  input  logic        bz_i,
  input  logic        bnz_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        mem_to_reg_i,
  input  logic        reg_write_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [63:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [63:0] dmem_rdata_i,
  output logic        pc_src_o,
  output logic [63:0] branch_addr_o,
  output logic        wb_valid_o,
  output logic        wb_reg_write_o,
  output logic [4:0]  wb_reg_o,
  output logic [63:0] wb_data_o,
  output logic        err_o,
  output logic        dbg_state_o
);

  // Handshake: an instruction is taken on a rising edge where valid_i=1 and
  // stall_o=0; while stall_o=1 upstream holds and valid_i is not looked at.

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam int CW = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DMEM_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [63:0]   addr_q, wdata_q, branch_addr_q, wb_data_q;
  logic [4:0]    rd_q, wb_reg_q;
  logic          we_q, m2r_q, rw_q;
  logic          wb_valid_q, wb_reg_write_q, pc_src_q, err_q;

  logic capture, mem_op, aligned, ack_hit, timeout, taken;
  logic unused_instr;

  assign capture = (state_q == IDLE) && valid_i;
  assign mem_op  = mem_read_i | mem_write_i;
  assign aligned = (alu_result_i[2:0] == 3'b000);
  assign ack_hit = (state_q == WAIT) && dmem_ack_i;
  assign timeout = (state_q == WAIT) && !dmem_ack_i && (cnt_q == CNT_LAST);
  assign taken   = b_i | (bz_i & zero_i) | (bnz_i & ~zero_i);
  assign unused_instr = ^instruction_i[31:5];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture && mem_op && aligned) state_d = WAIT;
      WAIT:    if (ack_hit || timeout)           state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_o     = (state_q == WAIT);
    dmem_req_o  = (state_q == WAIT);
    dmem_we_o   = (state_q == WAIT) && we_q;
    dbg_state_o = state_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      branch_addr_q  <= '0;
      wb_data_q      <= '0;
      rd_q           <= '0;
      wb_reg_q       <= '0;
      we_q           <= 1'b0;
      m2r_q          <= 1'b0;
      rw_q           <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      pc_src_q       <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      pc_src_q       <= 1'b0;
      if (state_q == WAIT) cnt_q <= cnt_q + CW'(1);
      if (capture) begin
        cnt_q         <= '0;
        addr_q        <= alu_result_i;
        wdata_q       <= store_data_i;
        branch_addr_q <= branch_addr_i;
        rd_q          <= instruction_i[4:0];
        we_q          <= mem_write_i;
        m2r_q         <= mem_to_reg_i;
        rw_q          <= reg_write_i;
        if (!mem_op) begin
          wb_valid_q     <= 1'b1;
          wb_reg_q       <= instruction_i[4:0];
          wb_data_q      <= alu_result_i;
          wb_reg_write_q <= reg_write_i && (instruction_i[4:0] != 5'd31);
          pc_src_q       <= taken;
        end else if (!aligned) begin
          // Misaligned access is refused outright and retired without a write.
          err_q      <= 1'b1;
          wb_valid_q <= 1'b1;
          wb_reg_q   <= instruction_i[4:0];
          wb_data_q  <= mem_to_reg_i ? 64'd0 : alu_result_i;
        end
      end
      if (ack_hit) begin
        wb_valid_q     <= 1'b1;
        wb_reg_q       <= rd_q;
        wb_data_q      <= m2r_q ? dmem_rdata_i : addr_q;
        wb_reg_write_q <= rw_q && !we_q && (rd_q != 5'd31);
      end else if (timeout) begin
        err_q      <= 1'b1;
        wb_valid_q <= 1'b1;
        wb_reg_q   <= rd_q;
        wb_data_q  <= '0;
      end
    end
  end

  assign dmem_addr_o    = addr_q;
  assign dmem_wdata_o   = wdata_q;
  assign branch_addr_o  = branch_addr_q;
  assign pc_src_o       = pc_src_q;
  assign wb_valid_o     = wb_valid_q;
  assign wb_reg_write_o = wb_reg_write_q;
  assign wb_reg_o       = wb_reg_q;
  assign wb_data_o      = wb_data_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus randomized transactions
// checked against a transaction-level model of the stage.
module tb_memory_stage;
  localparam int TO = 15;

  logic        clk, reset, valid_i;
  logic [31:0] instruction_i;
  logic [63:0] branch_addr_i, alu_result_i, store_data_i, dmem_rdata_i;
  logic        zero_i, b_i, bz_i, bnz_i, mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i;
  logic        dmem_ack_i;
  logic        stall_o, dmem_req_o, dmem_we_o, pc_src_o, wb_valid_o, wb_reg_write_o, err_o, dbg_state_o;
  logic [63:0] dmem_addr_o, dmem_wdata_o, branch_addr_o, wb_data_o;
  logic [4:0]  wb_reg_o;

  memory_stage #(.DMEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .instruction_i(instruction_i),
    .branch_addr_i(branch_addr_i), .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .zero_i(zero_i), .b_i(b_i), .bz_i(bz_i), .bnz_i(bnz_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_to_reg_i(mem_to_reg_i),
    .reg_write_i(reg_write_i), .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
    .dmem_rdata_i(dmem_rdata_i), .pc_src_o(pc_src_o), .branch_addr_o(branch_addr_o),
    .wb_valid_o(wb_valid_o), .wb_reg_write_o(wb_reg_write_o), .wb_reg_o(wb_reg_o),
    .wb_data_o(wb_data_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // transaction fields
  logic [63:0] t_alu, t_st, t_br, t_rdata;
  logic [4:0]  t_rd;
  logic        t_rw, t_mr, t_mw, t_m2r, t_b, t_bz, t_bnz, t_z;
  int          t_ack_delay;
  // observations
  int          o_req, o_stall, o_lat;
  logic        o_retired, o_rw, o_pc, o_unstable, o_extra, o_pc_outside;
  logic [4:0]  o_reg;
  logic [63:0] o_data, o_baddr, o_rdata;
  // model outputs
  int          e_req, e_lat;
  logic        e_rw, e_pc, e_err, e_cmp_data, err_m;
  logic [63:0] e_data;
  logic [63:0] exp_q[$];

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Transaction-level model: latency, request length and retirement values.
  task automatic model();
    logic is_mem, mis, acked;
    is_mem = t_mr | t_mw;
    mis    = is_mem && (t_alu[2:0] != 3'b000);
    acked  = is_mem && !mis && t_ack_delay >= 1 && t_ack_delay <= TO;
    e_req  = (!is_mem || mis) ? 0 : (acked ? t_ack_delay : TO);
    e_lat  = e_req + 1;
    e_cmp_data = !mis;
    if (!is_mem)    e_data = t_alu;
    else if (acked) e_data = t_m2r ? t_rdata : t_alu;
    else            e_data = 64'd0;
    e_rw  = (!is_mem || acked) && t_rw && !t_mw && (t_rd != 5'd31);
    e_pc  = !is_mem && (t_b || (t_bz && t_z) || (t_bnz && !t_z));
    err_m = err_m | mis | (is_mem && !mis && !acked);
    e_err = err_m;
  endtask

  task automatic set_txn(input logic [63:0] alu, input logic [4:0] rd, input logic rw,
                         input logic mr, input logic mw, input logic m2r, input int ack_delay);
    t_alu = alu; t_rd = rd; t_rw = rw; t_mr = mr; t_mw = mw; t_m2r = m2r;
    t_ack_delay = ack_delay; t_st = rnd64(); t_br = rnd64(); t_rdata = rnd64();
    t_b = 0; t_bz = 0; t_bnz = 0; t_z = 0;
  endtask

  // driver: called just after a falling edge, returns after one idle cycle
  task automatic do_txn();
    logic done;
    valid_i = 1; instruction_i = $urandom(); instruction_i[4:0] = t_rd;
    alu_result_i = t_alu; store_data_i = t_st; branch_addr_i = t_br;
    reg_write_i = t_rw; mem_read_i = t_mr; mem_write_i = t_mw; mem_to_reg_i = t_m2r;
    b_i = t_b; bz_i = t_bz; bnz_i = t_bnz; zero_i = t_z;
    @(posedge clk); #1;
    valid_i = 0; alu_result_i = rnd64(); store_data_i = rnd64(); branch_addr_i = rnd64();
    instruction_i = $urandom(); {reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i} = 4'($urandom());
    {b_i, bz_i, bnz_i, zero_i} = 4'($urandom());
    o_req = 0; o_stall = 0; o_lat = 0; o_unstable = 0; o_pc_outside = 0; done = 0;
    o_retired = 0; o_rdata = 'x;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (pc_src_o && !wb_valid_o) o_pc_outside = 1;
      if (wb_valid_o) begin
        done = 1; o_retired = 1; o_lat = cyc + 1;
        o_reg = wb_reg_o; o_data = wb_data_o; o_rw = wb_reg_write_o;
        o_pc = pc_src_o; o_baddr = branch_addr_o;
        if (stall_o) o_unstable = 1;
        valid_i = 0; dmem_ack_i = 0;
      end else begin
        if (stall_o) o_stall++;
        if (dmem_req_o) begin
          o_req++;
          if (dmem_addr_o !== t_alu || dmem_wdata_o !== t_st || dmem_we_o !== t_mw) o_unstable = 1;
        end
        dmem_ack_i = dmem_req_o && (o_req == t_ack_delay);
        dmem_rdata_i = dmem_ack_i ? t_rdata : rnd64();
        valid_i = dmem_req_o ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    dmem_ack_i = 1'($urandom_range(0, 1));
    @(negedge clk);
    o_extra = wb_valid_o | dmem_req_o | stall_o;
    dmem_ack_i = 0;
  endtask

  task automatic apply_reset();
    reset = 1; err_m = 0;
    #1;
    checks++;
    if ({stall_o, dmem_req_o, dmem_we_o, wb_valid_o, wb_reg_write_o, pc_src_o, err_o} !== 7'd0) begin
      errors++; $display("FAIL reset_flags got %b exp 0000000",
        {stall_o, dmem_req_o, dmem_we_o, wb_valid_o, wb_reg_write_o, pc_src_o, err_o});
    end
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({dmem_addr_o, dmem_wdata_o, branch_addr_o, wb_data_o} !== 256'd0) begin
      errors++; $display("FAIL reset_buses got %h %h %h %h exp 0", dmem_addr_o, dmem_wdata_o, branch_addr_o, wb_data_o);
    end
    checks++;
    if (wb_reg_o !== 5'd0 || dbg_state_o !== 1'b0) begin
      errors++; $display("FAIL reset_reg_state got %0d/%b exp 0/0", wb_reg_o, dbg_state_o);
    end
  endtask

  task automatic test_add();
    set_txn(64'h10, 5'd3, 1, 0, 0, 0, 0); model(); do_txn();
    checks++;
    if (o_lat !== 1 || o_reg !== 5'd3 || o_data !== 64'h10 || o_rw !== 1'b1) begin
      errors++; $display("FAIL add_retire got lat %0d rd %0d data %h we %b exp 1 3 10 1", o_lat, o_reg, o_data, o_rw);
    end
    checks++;
    if (o_stall !== 0 || o_unstable !== 1'b0 || o_extra !== 1'b0) begin
      errors++; $display("FAIL add_stall got stall %0d bad %b extra %b exp 0 0 0", o_stall, o_unstable, o_extra);
    end
  endtask

  task automatic test_ldur();
    set_txn(64'h40, 5'd5, 1, 1, 0, 1, 3); t_rdata = 64'hDEAD; model(); do_txn();
    checks++;
    if (o_stall !== 3 || o_req !== 3 || o_unstable !== 1'b0) begin
      errors++; $display("FAIL ldur_wait got stall %0d req %0d bad %b exp 3 3 0", o_stall, o_req, o_unstable);
    end
    checks++;
    if (o_lat !== 4 || o_data !== 64'hDEAD || o_reg !== 5'd5 || o_rw !== 1'b1 || o_pc !== 1'b0) begin
      errors++; $display("FAIL ldur_retire got lat %0d data %h rd %0d we %b pc %b exp 4 dead 5 1 0",
        o_lat, o_data, o_reg, o_rw, o_pc);
    end
  endtask

  task automatic test_cbz();
    set_txn(64'h7, 5'd31, 0, 0, 0, 0, 0); t_bz = 1; t_z = 1; t_br = 64'h200; model(); do_txn();
    checks++;
    if (o_pc !== 1'b1 || o_baddr !== 64'h200 || o_pc_outside !== 1'b0) begin
      errors++; $display("FAIL cbz_taken got pc %b addr %h stray %b exp 1 200 0", o_pc, o_baddr, o_pc_outside);
    end
    set_txn(64'h7, 5'd31, 0, 0, 0, 0, 0); t_bz = 1; t_z = 0; t_br = 64'h200; model(); do_txn();
    checks++;
    if (o_pc !== 1'b0 || o_pc_outside !== 1'b0) begin
      errors++; $display("FAIL cbz_not_taken got pc %b stray %b exp 0 0", o_pc, o_pc_outside);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a0, a1;
    a0 = rnd64(); a1 = rnd64();
    valid_i = 1; mem_read_i = 0; mem_write_i = 0; reg_write_i = 1;
    alu_result_i = a0; instruction_i = 32'd7;
    @(posedge clk); #1;
    alu_result_i = a1; instruction_i = 32'd9;
    @(negedge clk);
    checks++;
    if (wb_valid_o !== 1'b1 || wb_data_o !== a0 || wb_reg_o !== 5'd7) begin
      errors++; $display("FAIL b2b_first got v %b data %h rd %0d exp 1 %h 7", wb_valid_o, wb_data_o, wb_reg_o, a0);
    end
    @(posedge clk); #1; valid_i = 0;
    @(negedge clk);
    checks++;
    if (wb_valid_o !== 1'b1 || wb_data_o !== a1 || wb_reg_o !== 5'd9) begin
      errors++; $display("FAIL b2b_second got v %b data %h rd %0d exp 1 %h 9", wb_valid_o, wb_data_o, wb_reg_o, a1);
    end
    @(negedge clk);
    checks++;
    if (wb_valid_o !== 1'b0) begin
      errors++; $display("FAIL b2b_single_pulse got %b exp 0", wb_valid_o);
    end
  endtask

  task automatic test_stur_misaligned();
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL stur_err_before got %b exp 0", err_o); end
    set_txn(64'h44, 5'd2, 1, 0, 1, 0, 1); model(); do_txn();
    checks++;
    if (o_req !== 0 || o_lat !== 1 || o_rw !== 1'b0 || err_o !== 1'b1) begin
      errors++; $display("FAIL stur_misaligned got req %0d lat %0d we %b err %b exp 0 1 0 1", o_req, o_lat, o_rw, err_o);
    end
  endtask

  task automatic test_reset_in_wait();
    set_txn(64'h80, 5'd4, 1, 1, 0, 1, 0);
    valid_i = 1; instruction_i = 32'd4; alu_result_i = t_alu; mem_read_i = 1; mem_write_i = 0;
    @(posedge clk); #1; valid_i = 0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (stall_o !== 1'b1 || dmem_req_o !== 1'b1) begin
      errors++; $display("FAIL riw_in_wait got stall %b req %b exp 1 1", stall_o, dmem_req_o);
    end
    #2; reset = 1; err_m = 0; #1;
    checks++;
    if ({stall_o, dmem_req_o, wb_valid_o, err_o} !== 4'd0 || dmem_addr_o !== 64'd0) begin
      errors++; $display("FAIL riw_reset got %b addr %h exp 0000 0", {stall_o, dmem_req_o, wb_valid_o, err_o}, dmem_addr_o);
    end
    @(negedge clk); reset = 0; dmem_ack_i = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (wb_valid_o !== 1'b0 || dmem_req_o !== 1'b0 || wb_data_o !== 64'd0) begin
        errors++; $display("FAIL riw_late_ack got v %b req %b data %h exp 0 0 0", wb_valid_o, dmem_req_o, wb_data_o);
      end
    end
    dmem_ack_i = 0;
  endtask

  task automatic test_timeout();
    set_txn(64'h100, 5'd6, 1, 1, 0, 1, 0); model(); do_txn();
    checks++;
    if (o_req !== TO || o_lat !== TO + 1 || o_unstable !== 1'b0) begin
      errors++; $display("FAIL timeout_len got req %0d lat %0d bad %b exp %0d %0d 0", o_req, o_lat, o_unstable, TO, TO + 1);
    end
    checks++;
    if (o_data !== 64'd0 || o_rw !== 1'b0 || err_o !== 1'b1 || o_extra !== 1'b0) begin
      errors++; $display("FAIL timeout_retire got data %h we %b err %b extra %b exp 0 0 1 0", o_data, o_rw, err_o, o_extra);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      set_txn(rnd64(), 5'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()), 0);
      if ($urandom_range(0, 3) != 0) t_alu[2:0] = 3'b000;
      t_ack_delay = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
      {t_b, t_bz, t_bnz, t_z} = 4'($urandom());
      model();
      exp_q.push_back(e_data);
      do_txn();
      checks++;
      if (o_retired !== 1'b1 || o_lat !== e_lat || o_req !== e_req || o_stall !== e_req) begin
        errors++; $display("FAIL rand_timing[%0d] got ret %b lat %0d req %0d stall %0d exp 1 %0d %0d %0d",
          n, o_retired, o_lat, o_req, o_stall, e_lat, e_req, e_req);
      end
      checks++;
      if (o_reg !== t_rd || o_rw !== e_rw || o_pc !== e_pc || err_o !== e_err || o_baddr !== t_br) begin
        errors++; $display("FAIL rand_ctrl[%0d] got rd %0d we %b pc %b err %b ba %h exp %0d %b %b %b %h",
          n, o_reg, o_rw, o_pc, err_o, o_baddr, t_rd, e_rw, e_pc, e_err, t_br);
      end
      checks++;
      if (o_unstable !== 1'b0 || o_extra !== 1'b0 || o_pc_outside !== 1'b0) begin
        errors++; $display("FAIL rand_proto[%0d] got bad %b extra %b stray %b exp 0 0 0", n, o_unstable, o_extra, o_pc_outside);
      end
      if (e_cmp_data) begin
        checks++;
        if (o_data !== exp_q[0]) begin
          errors++; $display("FAIL rand_data[%0d] got %h exp %h", n, o_data, exp_q[0]);
        end
      end
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    reset = 1; valid_i = 0; instruction_i = 0; branch_addr_i = 0; alu_result_i = 0; store_data_i = 0;
    zero_i = 0; b_i = 0; bz_i = 0; bnz_i = 0; mem_read_i = 0; mem_write_i = 0; mem_to_reg_i = 0;
    reg_write_i = 0; dmem_ack_i = 0; dmem_rdata_i = 0; err_m = 0;
    @(negedge clk);
    test_reset();
    test_add();
    test_ldur();
    test_cbz();
    test_back_to_back();
    test_stur_misaligned();
    test_reset_in_wait();
    test_timeout();
    apply_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
